// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter around one external combinational ALU: operands are registered
// into the ALU, results and flags are registered back, one operation in flight at a time.
module alu_share_arbiter #(
    parameter int DATA_W    = 32,
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_x,
    input  logic [DATA_W-1:0] req0_y,
    input  logic [1:0]        req0_functionals,
    input  logic [2:0]        req0_logicfn,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_x,
    input  logic [DATA_W-1:0] req1_y,
    input  logic [1:0]        req1_functionals,
    input  logic [2:0]        req1_logicfn,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_value,
    output logic [3:0]        rsp_flags,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [1:0]        alu_functionals,
    output logic [2:0]        alu_logicfn,
    input  logic [DATA_W-1:0] alu_value,
    input  logic              alu_carry,
    input  logic              alu_zeroflag,
    input  logic              alu_msb,
    input  logic              alu_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;      // requester granted most recently
    logic                owner_q, owner_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic [1:0]          func_q, func_d;
    logic [2:0]          lfn_q, lfn_d;
    logic [DATA_W-1:0]   value_q, value_d;
    logic [3:0]          flags_q, flags_d;
    logic                rsp0_valid_q, rsp0_valid_d;
    logic                rsp1_valid_q, rsp1_valid_d;
    logic                grant0_s, grant1_s;
    logic                consume_s;

    // Grant selection: only in IDLE, never while reset is asserted.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_q == ST_IDLE) && !rst) begin
            if (req0_valid && req1_valid) begin
                if (RR_ENABLE && (last_q == 1'b0)) begin
                    grant1_s = 1'b1;
                end else begin
                    grant0_s = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
        end
    end

    assign consume_s = owner_q ? rsp1_ready : rsp0_ready;

    // Next-state and datapath register updates.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        x_d          = x_q;
        y_d          = y_q;
        func_d       = func_q;
        lfn_d        = lfn_q;
        value_d      = value_q;
        flags_d      = flags_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0_s || grant1_s) begin
                    owner_d = grant1_s;
                    last_d  = grant1_s;
                    x_d     = grant1_s ? req1_x : req0_x;
                    y_d     = grant1_s ? req1_y : req0_y;
                    func_d  = grant1_s ? req1_functionals : req0_functionals;
                    lfn_d   = grant1_s ? req1_logicfn : req0_logicfn;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                value_d      = alu_value;
                flags_d      = {alu_carry, alu_zeroflag, alu_msb, alu_overflow};
                rsp0_valid_d = ~owner_q;
                rsp1_valid_d = owner_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (consume_s) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            x_q          <= {DATA_W{1'b0}};
            y_q          <= {DATA_W{1'b0}};
            func_q       <= 2'b00;
            lfn_q        <= 3'b000;
            value_q      <= {DATA_W{1'b0}};
            flags_q      <= 4'b0000;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            x_q          <= x_d;
            y_q          <= y_d;
            func_q       <= func_d;
            lfn_q        <= lfn_d;
            value_q      <= value_d;
            flags_q      <= flags_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

    assign req0_ready      = grant0_s;
    assign req1_ready      = grant1_s;
    assign rsp0_valid      = rsp0_valid_q;
    assign rsp1_valid      = rsp1_valid_q;
    assign rsp_value       = value_q;
    assign rsp_flags       = flags_q;
    assign alu_x           = x_q;
    assign alu_y           = y_q;
    assign alu_functionals = func_q;
    assign alu_logicfn     = lfn_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a stand-in ALU model closes the loop, expected
// responses are queued at issue time and a negedge monitor compares them.
module tb_alu_share_arbiter;

    typedef struct {
        logic        owner;
        logic [31:0] value;
        logic [3:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_x = 32'd0, req0_y = 32'd0, req1_x = 32'd0, req1_y = 32'd0;
    logic [1:0]  req0_f = 2'b00, req1_f = 2'b00;
    logic [2:0]  req0_l = 3'b000, req1_l = 3'b000;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp_value;
    logic [3:0]  rsp_flags;
    logic [31:0] alu_x, alu_y, alu_value;
    logic [1:0]  alu_functionals;
    logic [2:0]  alu_logicfn;
    logic        alu_carry, alu_zeroflag, alu_msb, alu_overflow;

    logic        b_req0_valid = 1'b0, b_req1_valid = 1'b0;
    logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
    logic        b_rsp_ready = 1'b1;
    logic [31:0] b_x = 32'd5, b_y = 32'd7;
    logic [1:0]  b_f = 2'b00;
    logic [2:0]  b_l = 3'b000;
    logic [31:0] b_rsp_value, b_alu_x, b_alu_y, b_alu_value;
    logic [3:0]  b_rsp_flags;
    logic [1:0]  b_alu_functionals;
    logic [2:0]  b_alu_logicfn;
    logic        b_alu_carry, b_alu_zeroflag, b_alu_msb, b_alu_overflow;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // Stand-in ALU: 00 add, 01 sub (carry = borrow), 10 shift left, 11 logic.
    function automatic logic [35:0] alu_model(input logic [31:0] x, input logic [31:0] y,
                                              input logic [1:0] f, input logic [2:0] l);
        logic [32:0] s;
        logic [31:0] v;
        logic        c, o;
        s = 33'd0; c = 1'b0; o = 1'b0;
        case (f)
            2'b00: begin s = {1'b0, x} + {1'b0, y}; v = s[31:0]; c = s[32];
                         o = (x[31] == y[31]) && (v[31] != x[31]); end
            2'b01: begin v = x - y; c = (x < y); o = (x[31] != y[31]) && (v[31] != x[31]); end
            2'b10: v = x << y[4:0];
            default: begin
                case (l)
                    3'b000:  v = x & y;
                    3'b001:  v = x | y;
                    3'b010:  v = x ^ y;
                    default: v = ~x;
                endcase
            end
        endcase
        return {v, c, (v == 32'd0), v[31], o};
    endfunction

    assign {alu_value, alu_carry, alu_zeroflag, alu_msb, alu_overflow} =
        alu_model(alu_x, alu_y, alu_functionals, alu_logicfn);
    assign {b_alu_value, b_alu_carry, b_alu_zeroflag, b_alu_msb, b_alu_overflow} =
        alu_model(b_alu_x, b_alu_y, b_alu_functionals, b_alu_logicfn);

    alu_share_arbiter #(.DATA_W(32), .RR_ENABLE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req0_functionals(req0_f), .req0_logicfn(req0_l),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .req1_functionals(req1_f), .req1_logicfn(req1_l),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_value(rsp_value), .rsp_flags(rsp_flags),
        .alu_x(alu_x), .alu_y(alu_y), .alu_functionals(alu_functionals), .alu_logicfn(alu_logicfn),
        .alu_value(alu_value), .alu_carry(alu_carry), .alu_zeroflag(alu_zeroflag),
        .alu_msb(alu_msb), .alu_overflow(alu_overflow)
    );

    alu_share_arbiter #(.DATA_W(32), .RR_ENABLE(1'b0)) dut_fixed (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_x(b_x), .req0_y(b_y),
        .req0_functionals(b_f), .req0_logicfn(b_l),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_x(b_x), .req1_y(b_y),
        .req1_functionals(b_f), .req1_logicfn(b_l),
        .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp_ready),
        .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp_ready),
        .rsp_value(b_rsp_value), .rsp_flags(b_rsp_flags),
        .alu_x(b_alu_x), .alu_y(b_alu_y), .alu_functionals(b_alu_functionals),
        .alu_logicfn(b_alu_logicfn),
        .alu_value(b_alu_value), .alu_carry(b_alu_carry), .alu_zeroflag(b_alu_zeroflag),
        .alu_msb(b_alu_msb), .alu_overflow(b_alu_overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no DUT event within cycle budget (t=%0t)", name, $time);
    endtask

    // Monitor: every response cycle is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (rsp0_valid || rsp1_valid)) begin
            check("rsp_onehot", rsp0_valid & rsp1_valid, 1'b0);
            check("no_grant_in_resp", {req0_ready, req1_ready}, 2'b00);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp0_valid=%0b rsp1_valid=%0b, expected none",
                         rsp0_valid, rsp1_valid);
            end else begin
                check("rsp_owner", rsp1_valid, sb[0].owner);
                check("rsp_value", rsp_value, sb[0].value);
                check("rsp_flags", rsp_flags, sb[0].flags);
                if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))
                    void'(sb.pop_front());
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            timeout_fail("drain");
            sb.delete();
        end
    endtask

    task automatic set_req(input logic who, input logic [31:0] x, input logic [31:0] y,
                           input logic [1:0] f, input logic [2:0] l);
        if (who) begin
            req1_x = x; req1_y = y; req1_f = f; req1_l = l; req1_valid = 1'b1;
        end else begin
            req0_x = x; req0_y = y; req0_f = f; req0_l = l; req0_valid = 1'b1;
        end
    endtask

    // One lone request from an idle DUT: immediate grant, operands on alu_*, response two cycles on.
    task automatic single_op(input logic who, input logic [31:0] x, input logic [31:0] y,
                             input logic [1:0] f, input logic [2:0] l,
                             input logic [31:0] ev, input logic [3:0] ef);
        int n = 0;
        sb.push_back('{who, ev, ef});
        @(posedge clk); #1;
        set_req(who, x, y, f, l);
        @(negedge clk);
        check("immediate_grant", who ? req1_ready : req0_ready, 1'b1);
        check("other_ready_low", who ? req0_ready : req1_ready, 1'b0);
        while (!(who ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout_fail("grant_wait");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("exec_no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        check("alu_operands", {alu_x, alu_y}, {x, y});
        check("alu_codes", {alu_functionals, alu_logicfn}, {f, l});
        @(negedge clk);
        check("rsp_latency", who ? rsp1_valid : rsp0_valid, 1'b1);
        drain();
    endtask

    // Both requesters held valid for n grants; grant order is fixed by the queued expectations.
    task automatic dual(input int n, input logic first);
        int g = 0;
        int cyc = 0;
        for (int i = 0; i < n; i++) begin
            if ((first ^ (i % 2 == 1)) == 1'b0) sb.push_back('{1'b0, 32'd12, 4'b0000});
            else                                 sb.push_back('{1'b1, 32'd0, 4'b1100});
        end
        @(posedge clk); #1;
        set_req(1'b0, 32'd5, 32'd7, 2'b00, 3'b000);
        set_req(1'b1, 32'hFFFF_FFFF, 32'd1, 2'b00, 3'b000);
        while (g < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (req0_ready || req1_ready) g++;
        end
        if (g < n) timeout_fail("dual_grants");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
    endtask

    initial begin
        int n;
        int g0, g1;
        repeat (3) @(negedge clk);
        check("reset_ready", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 4'b0000);
        check("reset_regs", {rsp_value, rsp_flags, alu_functionals, alu_logicfn}, 41'd0);
        rst = 1'b0;

        // Basic add, then shift and subtract
        single_op(1'b0, 32'd5, 32'd7, 2'b00, 3'b000, 32'd12, 4'b0000);
        single_op(1'b0, 32'd1, 32'd4, 2'b10, 3'b010, 32'd16, 4'b0000);
        single_op(1'b0, 32'd0, 32'd3, 2'b01, 3'b010, 32'hFFFF_FFFD, 4'b1010);

        // Held response on req1 with req0 waiting; req0 must not be granted until consume
        sb.push_back('{1'b1, 32'd0, 4'b1100});
        sb.push_back('{1'b0, 32'd12, 4'b0000});
        @(posedge clk); #1;
        rsp1_ready = 1'b0;
        set_req(1'b1, 32'hFFFF_FFFF, 32'd1, 2'b00, 3'b000);
        n = 0;
        do begin @(negedge clk); n++; end while (!req1_ready && n < 20);
        if (!req1_ready) timeout_fail("hold_grant");
        @(posedge clk); #1;
        req1_valid = 1'b0;
        set_req(1'b0, 32'd5, 32'd7, 2'b00, 3'b000);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp1_valid && n < 20);
        if (!rsp1_valid) timeout_fail("hold_rsp");
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", rsp1_valid, 1'b1);
            if (k < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req0_ready && n < 20);
        if (!req0_ready) timeout_fail("after_hold_grant");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drain();

        // Lone req1 with the pointer favouring req1, then favouring req0
        single_op(1'b1, 32'h8000_0000, 32'h8000_0000, 2'b00, 3'b000, 32'd0, 4'b1101);
        single_op(1'b1, 32'h7FFF_FFFF, 32'd1, 2'b00, 3'b000, 32'h8000_0000, 4'b0011);

        // Reset during EXEC drops the operation
        @(posedge clk); #1;
        set_req(1'b0, 32'd3, 32'd4, 2'b00, 3'b000);
        n = 0;
        do begin @(negedge clk); n++; end while (!req0_ready && n < 20);
        if (!req0_ready) timeout_fail("rst_grant");
        @(posedge clk); #1;
        req1_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_async_ctrl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_flags,
                                 alu_functionals, alu_logicfn}, 13'd0);
        check("rst_async_value", rsp_value, 32'd0);
        check("rst_async_alu", {alu_x, alu_y}, 64'd0);
        @(negedge clk);
        check("ready_in_reset", {req0_ready, req1_ready}, 2'b00);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Both valid after reset: req0 first, then strict alternation
        dual(4, 1'b0);

        // Fixed-priority instance: req0 wins every tie
        @(posedge clk); #1;
        b_req0_valid = 1'b1;
        b_req1_valid = 1'b1;
        g0 = 0;
        g1 = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (b_req0_ready) g0++;
            if (b_req1_ready) g1++;
            if (b_rsp0_valid) check("fixed_value", {b_rsp_value, b_rsp_flags}, {32'd12, 4'b0000});
        end
        @(posedge clk); #1;
        b_req0_valid = 1'b0;
        b_req1_valid = 1'b0;
        check("fixed_grants0", g0, 4);
        check("fixed_grants1", g1, 0);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
